pwm_peripheral: RTL



---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_timebase.sv | 44 ++++
 rtl/pwm_peripheral.sv | 65 ++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM peripheral and its timebase.
package pwm_pkg;

  localparam logic [7:0] PWM_CNT_MAX      = 8'd254;
  localparam int         PWM_PERIOD_TICKS = 255;
  localparam int         PRESCALE_DEFAULT = 13;
  localparam int         PWM_NUM_PINS     = 16;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler followed by an 8-bit period counter (0..254).
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] pwm_cnt_o,
  output logic       tick_o,
  output logic       load_o
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  logic [7:0] pre_cnt_q, pre_cnt_d;
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic       tick;

  always_comb begin
    tick      = (pre_cnt_q == PRE_LAST);
    pre_cnt_d = tick ? 8'd0 : pre_cnt_q + 8'd1;
    pwm_cnt_d = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = (pwm_cnt_q == PWM_CNT_MAX) ? 8'd0 : pwm_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= 8'd0;
      pwm_cnt_q <= 8'd0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_cnt_o = pwm_cnt_q;
  assign tick_o    = tick;
  // First clock of a period; also true on the first cycle after reset release.
  assign load_o    = (pre_cnt_q == 8'd0) && (pwm_cnt_q == 8'd0) && !rst;

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pins low, static high or PWM from the control registers; the duty
// cycle is shadowed at period start so a pin never glitches mid-period.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              en_reg_out_7_0,
  input  logic [7:0]              en_reg_out_15_8,
  input  logic [7:0]              en_reg_pwm_7_0,
  input  logic [7:0]              en_reg_pwm_15_8,
  input  logic [7:0]              pwm_duty_cycle,
  output logic [PWM_NUM_PINS-1:0] out,
  output logic                    period_start
);

  logic [7:0]              pwm_cnt;
  logic                    tick;
  logic                    load;
  logic [7:0]              duty_shadow_q, duty_shadow_d;
  logic [7:0]              duty_eff;
  logic                    pwm_raw;
  logic [PWM_NUM_PINS-1:0] en_out, en_pwm;
  logic [PWM_NUM_PINS-1:0] out_q, out_d;
  logic                    period_start_q;

  pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk       (clk),
    .rst       (rst),
    .pwm_cnt_o (pwm_cnt),
    .tick_o    (tick),
    .load_o    (load)
  );

  always_comb begin
    en_out        = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm        = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    // Bypass the shadow on load so a new duty applies from the first tick.
    duty_eff      = load ? pwm_duty_cycle : duty_shadow_q;
    duty_shadow_d = duty_eff;
    pwm_raw       = (pwm_cnt < duty_eff);
    out_d         = en_out & (~en_pwm | {PWM_NUM_PINS{pwm_raw}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow_q  <= 8'h00;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= load;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

  wrap_then_load_a: assert property (@(posedge clk) disable iff (rst)
    (tick && pwm_cnt == PWM_CNT_MAX) |=> load);

endmodule
